matrix_scanner: RTL and testbench
=================================

MATRIX_SCANNER -- requirements
Module: matrix_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 16: number of matrix rows; a power of two, 2 or more.
REQ-002 SHALL have parameter COLS, default 16: number of matrix columns; 2 or more.
REQ-003 SHALL have parameter CLKDIV, default 2048: clk cycles per scan tick; 2 or more.
REQ-004 SHALL have parameter BRIGHT_W, default 2: brightness width; the SHOW phase lasts 2**BRIGHT_W ticks.
REQ-005 SHALL have parameter ROW_SWAP, default 1: when 1, scan row r displays buffer row r^1 (pairwise board wiring fix).
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port wr_en, input, 1 bit: write wr_data into back-bank row wr_row.
REQ-009 SHALL have port wr_row, input, $clog2(ROWS) bits: write row address.
REQ-010 SHALL have port wr_data, input, COLS bits: row pixels; bit c = column c; 1 = lit.
REQ-011 SHALL have port swap_req, input, 1 bit: single-cycle request to swap banks at the next frame boundary.
REQ-012 SHALL have port brightness, input, BRIGHT_W bits: per-row on-time in ticks.
REQ-013 SHALL have ports rclk, rsdi, cclk, csdi, le, oeb, each an output of 1 bit: row shift clock, row data (active-low token), column shift clock, column data, column latch, output-enable (active-low).
REQ-014 SHALL have port frame_start, output, 1 bit: one-cycle pulse when row 0 begins SHIFT.
REQ-015 SHALL have port swap_done, output, 1 bit: one-cycle pulse on the cycle the banks swap.

Function
REQ-016 SHALL assert an internal tick when a divider counting 0..CLKDIV-1 reaches CLKDIV-1; all scan state and scan outputs SHALL change only on tick cycles.
REQ-017 SHALL run the FSM SHIFT -> LATCH -> SHOW -> SHIFT, with the row index incrementing modulo ROWS on leaving SHOW.
REQ-018 SHALL copy buffer row (ROW_SWAP ? row^1 : row) of the front bank into a row shift register on SHIFT entry.
REQ-019 SHIFT SHALL last 2*COLS ticks, bit k = 0..COLS-1: in phase 0 drive csdi = data[COLS-1-k] with cclk = 0 and rclk = 0; in phase 1 drive cclk = 1.
REQ-020 During SHIFT bit 0, rsdi SHALL be 0 if row == 0 and 1 otherwise, rclk SHALL be 1 in phase 1, and rsdi SHALL be 1 at all other times.
REQ-021 LATCH SHALL last 1 tick with le = 1, cclk = 0 and rclk = 0; le SHALL be 0 in all other states.
REQ-022 SHOW SHALL last 2**BRIGHT_W ticks, with oeb = 0 while show_cnt < brightness_latched and oeb = 1 otherwise; brightness SHALL be sampled on SHOW entry.
REQ-023 oeb SHALL be 1 throughout SHIFT and LATCH (blanking); brightness 0 SHALL give a fully dark row.
REQ-024 Row period SHALL equal 2*COLS + 1 + 2**BRIGHT_W ticks.
REQ-025 On the tick leaving SHOW of row ROWS-1 (the frame boundary), if swap_pending or swap_req, SHALL toggle front/back, clear pending, and pulse swap_done on that cycle.
REQ-026 swap_req away from the boundary SHALL set swap_pending; a repeat request while pending SHALL have no additional effect.
REQ-027 wr_en SHALL write the bank that is back at the start of that cycle, including on a swap cycle (that write becomes visible immediately in the new front bank).
REQ-028 The front bank SHALL never be written; an image becomes visible only after a swap, and no earlier than the frame following the swap.
REQ-029 frame_start SHALL pulse for 1 clk on the tick entering SHIFT with row == 0, including the first SHIFT after reset.

Reset
REQ-030 While reset_n == 0 on a clk edge: divider = 0, FSM = SHIFT bit 0 phase 0, row = 0, front bank = 0, swap_pending = 0, and both banks cleared to 0.
REQ-031 Reset outputs SHALL be: rclk = 0, rsdi = 1, cclk = 0, csdi = 0, le = 0, oeb = 1, frame_start = 0, swap_done = 0.
REQ-032 Reset asserted mid-frame SHALL abort the scan immediately; the first tick after release SHALL start row 0 SHIFT.

Verification
REQ-033 Bench (ROWS=16, COLS=16, CLKDIV=2, BRIGHT_W=2): reset release -> frame_start pulses every 1184 clk and each row lasts 74 clk.
REQ-034 Write row 3 = 16'h8001, then swap_req -> swap_done at the next boundary; in the next frame, scan row 2 (ROW_SWAP=1) shifts csdi 1,0x14,1 and rows 0..15 otherwise shift all zeros.
REQ-035 Brightness sweep 0 / 1 / 3 -> oeb low for 0 / 2 / 6 clk per row, never low during SHIFT or LATCH.
REQ-036 swap_req twice mid-frame plus a write on the boundary cycle -> exactly one swap_done, and the boundary write is visible in the new front bank.
REQ-037 Reset pulsed mid-SHOW of row 7 -> outputs take their reset values on the next edge, then row 0 scan with frame_start after release.

Source files
------------

// File: rtl/matrix_scanner.sv
// matrix_scanner: double-buffered LED matrix row scanner.
//
// Scans one row at a time: shifts the row's column bits out serially, latches
// them into the column drivers, then enables the outputs for a
// brightness-controlled number of ticks. Two image banks: the host writes the
// back bank while the front bank is displayed; swaps happen only at frame
// boundaries.
//
// Ports:
//   clk, reset_n        clock (rising edge), synchronous active-low reset
//   wr_en/wr_row/wr_data write one row of pixels into the back bank
//   swap_req            request a bank swap at the next frame boundary
//   brightness          per-row on-time in ticks (sampled on SHOW entry)
//   rclk, rsdi          row shift clock / active-low row token
//   cclk, csdi, le      column shift clock / data / latch
//   oeb                 active-low output enable
//   frame_start         pulse when row 0 starts shifting
//   swap_done           pulse on the cycle the banks swap
module matrix_scanner #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int CLKDIV   = 2048,
  parameter int BRIGHT_W = 2,
  parameter int ROW_SWAP = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [$clog2(ROWS)-1:0]  wr_row,
  input  logic [COLS-1:0]          wr_data,
  input  logic                     swap_req,
  input  logic [BRIGHT_W-1:0]      brightness,
  output logic                     rclk,
  output logic                     rsdi,
  output logic                     cclk,
  output logic                     csdi,
  output logic                     le,
  output logic                     oeb,
  output logic                     frame_start,
  output logic                     swap_done
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(CLKDIV);
  localparam int KW = $clog2(COLS);

  typedef enum logic [1:0] {S_SHIFT, S_LATCH, S_SHOW} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       div;
  logic                tick;
  logic [KW-1:0]       bit_idx, bit_nxt;
  logic                phase, phase_nxt;
  logic [BRIGHT_W-1:0] show_cnt, show_nxt;
  logic [RW-1:0]       row, row_nxt;

  logic [1:0][ROWS-1:0][COLS-1:0] bank;
  logic                front, swap_pending;
  logic [COLS-1:0]     sreg, row_data;
  logic [RW-1:0]       buf_row;
  logic [BRIGHT_W-1:0] bright_l;
  logic                first_bit, boundary;
  logic                rclk_n, rsdi_n, cclk_n, csdi_n, le_n, oeb_n;

  assign tick      = (div == CW'(CLKDIV - 1));
  assign buf_row   = (ROW_SWAP != 0) ? (row ^ RW'(1)) : row;
  assign row_data  = bank[front][buf_row];
  assign first_bit = (state == S_SHIFT) && (bit_idx == '0) && !phase;
  assign boundary  = tick && (state == S_SHOW) && (show_cnt == '1) &&
                     (row == RW'(ROWS - 1));

  // Outputs are registered one tick behind the state they describe: on each
  // tick the outputs for the current state are loaded and the state advances.
  // This keeps reset outputs independent of the reset state's own outputs.
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_idx;
    phase_nxt = phase;
    show_nxt  = show_cnt;
    row_nxt   = row;
    rclk_n    = 1'b0;
    rsdi_n    = 1'b1;
    cclk_n    = 1'b0;
    csdi_n    = 1'b0;
    le_n      = 1'b0;
    oeb_n     = 1'b1;
    case (state)
      S_SHIFT: begin
        // On the first bit the shift register is still being loaded, so the
        // MSB comes straight from the bank (keeps a same-cycle swap write visible).
        csdi_n = first_bit ? row_data[COLS-1] : sreg[COLS-1];
        cclk_n = phase;
        if (bit_idx == '0) begin
          rsdi_n = (row != '0);
          rclk_n = phase;
        end
        if (!phase) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (bit_idx == KW'(COLS - 1)) begin
            bit_nxt   = '0;
            state_nxt = S_LATCH;
          end else begin
            bit_nxt = bit_idx + 1'b1;
          end
        end
      end
      S_LATCH: begin
        le_n      = 1'b1;
        show_nxt  = '0;
        state_nxt = S_SHOW;
      end
      S_SHOW: begin
        oeb_n = !(show_cnt < bright_l);
        if (show_cnt == '1) begin
          state_nxt = S_SHIFT;
          row_nxt   = row + 1'b1;
        end else begin
          show_nxt = show_cnt + 1'b1;
        end
      end
      default: state_nxt = S_SHIFT;
    endcase
  end

  // Scan state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_SHIFT;
      bit_idx  <= '0;
      phase    <= 1'b0;
      show_cnt <= '0;
      row      <= '0;
    end else if (tick) begin
      state    <= state_nxt;
      bit_idx  <= bit_nxt;
      phase    <= phase_nxt;
      show_cnt <= show_nxt;
      row      <= row_nxt;
    end
  end

  // Divider, banks, swap control and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div          <= '0;
      bank         <= '0;
      front        <= 1'b0;
      swap_pending <= 1'b0;
      sreg         <= '0;
      bright_l     <= '0;
      rclk         <= 1'b0;
      rsdi         <= 1'b1;
      cclk         <= 1'b0;
      csdi         <= 1'b0;
      le           <= 1'b0;
      oeb          <= 1'b1;
      frame_start  <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 1'b1;

      // Always targets the pre-swap back bank, so a boundary write lands in
      // the bank that becomes front on this very edge.
      if (wr_en) bank[~front][wr_row] <= wr_data;

      if (boundary && (swap_pending || swap_req)) begin
        front        <= ~front;
        swap_pending <= 1'b0;
        swap_done    <= 1'b1;
      end else begin
        swap_done <= 1'b0;
        if (swap_req) swap_pending <= 1'b1;
      end

      frame_start <= tick && first_bit && (row == '0);

      if (tick) begin
        rclk <= rclk_n;
        rsdi <= rsdi_n;
        cclk <= cclk_n;
        csdi <= csdi_n;
        le   <= le_n;
        oeb  <= oeb_n;
        if (first_bit)                      sreg <= row_data;
        else if (state == S_SHIFT && phase) sreg <= sreg << 1;
        if (state == S_LATCH) bright_l <= brightness;
      end
    end
  end
endmodule

// File: tb/tb_matrix_scanner.sv
// Directed bench for matrix_scanner (ROWS=16, COLS=16, CLKDIV=2, BRIGHT_W=2).
// Row period 37 ticks = 74 clk, frame 1184 clk. Inputs are driven and outputs
// sampled on the falling edge.
module tb_matrix_scanner;
  logic        clk = 1'b0;
  logic        reset_n, wr_en, swap_req;
  logic [3:0]  wr_row;
  logic [15:0] wr_data;
  logic [1:0]  brightness;
  logic        rclk, rsdi, cclk, csdi, le, oeb, frame_start, swap_done;

  always #5 clk = ~clk;

  matrix_scanner #(.ROWS(16), .COLS(16), .CLKDIV(2), .BRIGHT_W(2), .ROW_SWAP(1)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_row(wr_row),
    .wr_data(wr_data), .swap_req(swap_req), .brightness(brightness),
    .rclk(rclk), .rsdi(rsdi), .cclk(cclk), .csdi(csdi), .le(le), .oeb(oeb),
    .frame_start(frame_start), .swap_done(swap_done)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] rows [16];
  int oeb_low, oeb_bad, sd_cnt, fs_cnt, le_cnt, rise0, rise1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rclk"}, rclk, 0);
    chk({tag, "_rsdi"}, rsdi, 1);
    chk({tag, "_cclk"}, cclk, 0);
    chk({tag, "_csdi"}, csdi, 0);
    chk({tag, "_le"}, le, 0);
    chk({tag, "_oeb"}, oeb, 1);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_swap_done"}, swap_done, 0);
  endtask

  // Waits (bounded) for frame_start; expects it 2 clk after reset release.
  task automatic wait_first_fs(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 3000);
    chk({tag, "_fs_latency"}, n, 2);
  endtask

  // Observes one full frame starting at the frame_start sample. Optional
  // stimulus at given sample positions (-1 = none).
  task automatic run_frame(input int sr1, input int sr2, input int wp,
                           input logic [3:0] wrow, input logic [15:0] wdat);
    int   ri = -1;
    logic pr = 1'b0;
    logic pc = 1'b0;
    for (int i = 0; i < 16; i++) rows[i] = '0;
    oeb_low = 0; oeb_bad = 0; sd_cnt = 0; fs_cnt = 0; le_cnt = 0;
    rise0 = -1; rise1 = -1;
    chk("frame_start_at_frame_begin", frame_start, 1);
    chk("row0_token_low", rsdi, 0);
    for (int p = 0; p < 1184; p++) begin
      if (p == 74) chk("row1_token_high", rsdi, 1);
      if (rclk && !pr) begin
        ri++;
        if (ri == 0) rise0 = p;
        if (ri == 1) rise1 = p;
      end
      if (cclk && !pc && ri >= 0 && ri < 16) rows[ri] = {rows[ri][14:0], csdi};
      pr = rclk;
      pc = cclk;
      if (!oeb) begin
        oeb_low++;
        if ((p % 74) < 66) oeb_bad++;
      end
      if (le) le_cnt++;
      if (swap_done) sd_cnt++;
      if (frame_start) fs_cnt++;
      swap_req = (p == sr1) || (p == sr2);
      wr_en    = (p == wp);
      wr_row   = wrow;
      wr_data  = wdat;
      @(negedge clk);
    end
    swap_req = 1'b0;
    wr_en    = 1'b0;
  endtask

  task automatic check_frame(input string nm, input int exp_oeb, input int exp_sd,
                             input logic [3:0] lit_row, input logic [15:0] lit_val);
    int others = 0;
    for (int i = 0; i < 16; i++)
      if (i != int'(lit_row) && rows[i] !== 16'h0) others++;
    chk({nm, "_lit_row"}, rows[lit_row], lit_val);
    chk({nm, "_other_rows_nonzero"}, others, 0);
    chk({nm, "_oeb_low_clk"}, oeb_low, exp_oeb);
    chk({nm, "_oeb_low_outside_show"}, oeb_bad, 0);
    chk({nm, "_swap_done_cnt"}, sd_cnt, exp_sd);
    chk({nm, "_frame_start_cnt"}, fs_cnt, 1);
    chk({nm, "_le_clk"}, le_cnt, 32);
    chk({nm, "_row_period"}, rise1 - rise0, 74);
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    wr_row = '0; wr_data = '0; brightness = 2'd0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    reset_n = 1'b1;
    wait_first_fs("release");

    // A: blank image, brightness 0 -> fully dark
    run_frame(-1, -1, -1, 4'd0, 16'h0);
    check_frame("A", 0, 0, 4'd2, 16'h0);

    // B: write row 3 into back bank, request swap mid-frame
    brightness = 2'd1;
    run_frame(20, -1, 10, 4'd3, 16'h8001);
    check_frame("B", 32, 1, 4'd2, 16'h0);

    // C: new image; buffer row 3 shows on scan row 2
    run_frame(-1, -1, -1, 4'd0, 16'h0);
    check_frame("C", 32, 0, 4'd2, 16'h8001);

    // D: brightness 3 -> 6 clk per row
    brightness = 2'd3;
    run_frame(-1, -1, -1, 4'd0, 16'h0);
    check_frame("D", 96, 0, 4'd2, 16'h8001);

    // E: two swap requests plus a write on the boundary cycle
    run_frame(100, 300, 1181, 4'd4, 16'h00F0);
    check_frame("E", 96, 1, 4'd2, 16'h8001);

    // F: boundary write visible in new front bank (buffer row 4 -> scan row 5)
    run_frame(-1, -1, -1, 4'd0, 16'h0);
    check_frame("F", 96, 0, 4'd5, 16'h00F0);

    // G: reset mid-SHOW of row 7
    for (int p = 0; p < 586; p++) @(negedge clk);
    chk("row7_show_oeb_low", oeb, 0);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_outs("midshow_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_first_fs("rerelease");
    run_frame(-1, -1, -1, 4'd0, 16'h0);
    check_frame("H", 96, 0, 4'd5, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
